// File: rtl/multibyte_carry_sequencer.sv
// Byte-serial wide adder: one 8-bit ripple-carry slice per cycle, carry registered between bytes.
// Define SIGNED_OVF_EN to build the registered signed-overflow output `ovf`.
module multibyte_carry_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
`ifdef SIGNED_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int IDX_W = (NBYTES > 2) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Team 8-bit ripple-carry slice: returns {carry_out, sum}.
    function automatic logic [8:0] add8_ripple(input logic [7:0] x,
                                               input logic [7:0] y,
                                               input logic       ci);
        logic [7:0] s;
        logic       c;
        s = '0;
        c = ci;
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic [1:0]                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       carry_q, carry_d;
    logic [NBYTES-1:0][7:0]     a_q, b_q;
    logic [NBYTES-1:0][7:0]     sum_q;
    logic                       cout_q, cout_d;
    logic [7:0]                 a_byte, b_byte;
    logic [8:0]                 slice;
    logic                       accept;
    logic                       last_step;
`ifdef SIGNED_OVF_EN
    logic                       ovf_q, ovf_d;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

    assign a_byte    = a_q[idx_q];
    assign b_byte    = b_q[idx_q];
    assign slice     = add8_ripple(a_byte, b_byte, carry_q);
    assign last_step = (state_q == ADD) && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADD;
                    idx_d   = '0;
                    carry_d = cin;
                end
            end
            ADD: begin
                carry_d = slice[8];
                idx_d   = idx_q + IDX_W'(1);
                if (last_step) begin
                    // Top byte: publish carry and overflow together, park idx at 0.
                    cout_d  = slice[8];
`ifdef SIGNED_OVF_EN
                    ovf_d   = (a_byte[7] == b_byte[7]) && (slice[7] != a_byte[7]);
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Result bytes are overwritten one at a time; untouched bytes keep stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state_q == ADD) begin
            sum_q[idx_q] <= slice[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

endmodule

// File: tb/tb_multibyte_carry_sequencer.sv
// Bench for multibyte_carry_sequencer (NBYTES=4): vector table, corner sequences, random vs. model.
module tb_multibyte_carry_sequencer;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   a_i, b_i;
    logic          cin_i;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   sum_o;
    logic          cout_o;
`ifdef SIGNED_OVF_EN
    logic          ovf_o;
`endif

    int checks = 0;
    int errors = 0;

    multibyte_carry_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum_o),
        .cout      (cout_o)
`ifdef SIGNED_OVF_EN
        ,
        .ovf       (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc);
        a_i      = ta;
        b_i      = tb_v;
        cin_i    = tc;
        in_valid = 1'b1;
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result(input int stall);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic check_model(input string name, input logic [31:0] ta,
                               input logic [31:0] tb_v, input logic tc);
        logic [32:0] full;
        full = {1'b0, ta} + {1'b0, tb_v} + {32'd0, tc};
        chk({name, "_sum"}, {32'd0, sum_o}, {32'd0, full[31:0]});
        chk({name, "_cout"}, {63'd0, cout_o}, {63'd0, full[32]});
`ifdef SIGNED_OVF_EN
        chk({name, "_ovf"}, {63'd0, ovf_o},
            {63'd0, (ta[31] == tb_v[31]) && (full[31] != ta[31])});
`endif
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] hold_sum;
        logic        hold_cout;
        logic [31:0] ra, rb;
        logic        rc;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; cin_i = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_sum", {32'd0, sum_o}, 64'd0);
        chk("rst_cout", {63'd0, cout_o}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_result(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NB));
            chk($sformatf("vec%0d_sum", i), {32'd0, sum_o}, {32'd0, vecs[i].exp_sum});
            chk($sformatf("vec%0d_cout", i), {63'd0, cout_o}, {63'd0, vecs[i].exp_cout});
`ifdef SIGNED_OVF_EN
            chk($sformatf("vec%0d_ovf", i), {63'd0, ovf_o}, {63'd0, vecs[i].exp_ovf});
`endif
            release_result(i % 2);
        end

        // Backpressure: result must hold while inputs churn.
        issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        wait_result(lat);
        hold_sum  = sum_o;
        hold_cout = cout_o;
        check_model("bp", 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("bp_sum_stable", {32'd0, sum_o}, {32'd0, hold_sum});
            chk("bp_cout_stable", {63'd0, cout_o}, {63'd0, hold_cout});
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        release_result(0);

        // Asynchronous reset mid-cycle while a result is presented.
        issue(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
        wait_result(lat);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("arst_sum", {32'd0, sum_o}, 64'd0);
        chk("arst_cout", {63'd0, cout_o}, 64'd0);
`ifdef SIGNED_OVF_EN
        chk("arst_ovf", {63'd0, ovf_o}, 64'd0);
`endif
        @(negedge clk); rst = 1'b0;
        #1;
        chk("arst_rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Reset pulse during the second ADD cycle abandons the operation.
        issue(32'h0102_0304, 32'h0506_0708, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("madd_in_ready_rst", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("madd_in_ready_rel", {63'd0, in_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("madd_no_result", 64'(seen), 64'd0);
        issue(32'h0000_0002, 32'h0000_0003, 1'b0);
        wait_result(lat);
        chk("madd_next_latency", 64'(lat), 64'(NB));
        chk("madd_next_sum", {32'd0, sum_o}, 64'h5);
        release_result(0);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (n % 5 == 0) rb = ~ra;
            issue(ra, rb, rc);
            wait_result(lat);
            chk("rnd_latency", 64'(lat), 64'(NB));
            check_model("rnd", ra, rb, rc);
            release_result(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
